rom_snd_loader: RTL

- Writer side of the sound-board program memory: a 4096x8 RAM filled from a byte stream at boot, then read by the sound CPU through the same one-cycle registered read port the sound ROM presents.
- Holds the sound CPU in reset until a full image has been accepted.
- Sits between the boot/config byte source and the sound CPU address/data bus.

---
 rtl/rom_snd_loader.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/rom_snd_loader.sv
// Purpose : boot-time writer for the 4096x8 sound program RAM; holds the sound CPU in reset until a full image is in.
// Latency : one-cycle registered read (rd_data_o); a byte offered with wr_valid_i is written on the edge it is accepted.
// Backpressure: wr_ready_o is high only in LOAD; it drops the cycle after the last byte, so no byte beyond LOAD_LEN is accepted.
//
// Ports: clock_i / reset_n_i (synchronous, active-low); start_i begins or restarts a load at address 0;
//        wr_data_i / wr_valid_i / wr_ready_o form the image byte stream; rd_address_i / rd_data_o are the
//        sound CPU read port; loading_o, done_o, cpu_reset_n_o report load status; checksum_o is the image byte sum.
// Build option: define SND_LOADER_CHECKSUM_EN to build the 16-bit checksum accumulator; otherwise checksum_o is 0.
module rom_snd_loader #(
  parameter int ADDR_W   = 12,
  parameter int LOAD_LEN = 4096
) (
  input  logic              clock_i,
  input  logic              reset_n_i,
  input  logic              start_i,
  input  logic [7:0]        wr_data_i,
  input  logic              wr_valid_i,
  output logic              wr_ready_o,
  input  logic [ADDR_W-1:0] rd_address_i,
  output logic [7:0]        rd_data_o,
  output logic              loading_o,
  output logic              done_o,
  output logic              cpu_reset_n_o,
  output logic [15:0]       checksum_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Count value held while the final byte of the image is being accepted.
  localparam logic [ADDR_W:0] LAST_CNT = (ADDR_W + 1)'(LOAD_LEN - 1);

  logic [7:0]        mem [0:(1 << ADDR_W) - 1];

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic [7:0]        rd_data_q, rd_data_d;
  logic              wr_en;

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    cnt_d         = cnt_q;
    wr_en         = 1'b0;
    wr_ready_o    = 1'b0;
    loading_o     = 1'b0;
    done_o        = 1'b0;
    cpu_reset_n_o = 1'b0;

    case (state_q)
      ST_IDLE: begin
      end
      ST_LOAD: begin
        wr_ready_o = 1'b1;
        loading_o  = 1'b1;
        if (wr_valid_i) begin
          wr_en  = 1'b1;
          addr_d = addr_q + 1'b1;
          cnt_d  = cnt_q + 1'b1;
          if (cnt_q == LAST_CNT) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        done_o        = 1'b1;
        cpu_reset_n_o = 1'b1;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // start_i wins over any byte offered on the same edge: that byte is dropped.
    if (start_i) begin
      state_d = ST_LOAD;
      addr_d  = '0;
      cnt_d   = '0;
      wr_en   = 1'b0;
    end
  end

  always_comb begin
    rd_data_d = mem[rd_address_i];
  end

  always_ff @(posedge clock_i) begin
    if (!reset_n_i) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      cnt_q     <= '0;
      rd_data_q <= 8'h00;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      cnt_q     <= cnt_d;
      rd_data_q <= rd_data_d;
    end
  end

  // Memory has no reset so a partial image survives an aborted load; reset still blocks the write.
  always_ff @(posedge clock_i) begin
    if (wr_en && reset_n_i) begin
      mem[addr_q] <= wr_data_i;
    end
  end

  assign rd_data_o = rd_data_q;

`ifdef SND_LOADER_CHECKSUM_EN
  logic [15:0] checksum_q, checksum_d;

  always_comb begin
    checksum_d = checksum_q;
    if (wr_en) begin
      checksum_d = checksum_q + {8'h00, wr_data_i};
    end
    if (start_i) begin
      checksum_d = 16'h0000;
    end
  end

  always_ff @(posedge clock_i) begin
    if (!reset_n_i) begin
      checksum_q <= 16'h0000;
    end else begin
      checksum_q <= checksum_d;
    end
  end

  assign checksum_o = checksum_q;
`else
  assign checksum_o = 16'h0000;
`endif

endmodule
